rect_plotter: RTL and testbench
===============================

Name: rect_plotter

Overview:
- Pixel-stream generator for the game datapath. It accepts one rectangle-fill or screen-clear request, then drives the vga_adapter plot interface (x, y, colour, plot) with one pixel per clock.
- Used to draw blocks, the target and the start block, and to clear the 160x120 framebuffer between games.
- The game datapath is the requester. vga_adapter is the sink; it has no backpressure, and every plot-high cycle is written.

Parameters:
- SCREEN_W, 160, framebuffer width in pixels. x is legal in 0..SCREEN_W-1.
- SCREEN_H, 120, framebuffer height in pixels. y is legal in 0..SCREEN_H-1.

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset_n  input  1  reset. One clock; reset is synchronous and active-low.
- start  input  1  request strobe, sampled on the rising edge.
- clear  input  1  qualifies start: 1 = clear the whole screen, 0 = fill a rectangle.
- x0  input  8  top-left x of the rectangle.
- y0  input  7  top-left y of the rectangle.
- width  input  8  rectangle width in pixels. 0 = empty.
- height  input  7  rectangle height in pixels. 0 = empty.
- colour_in  input  3  fill colour (RGB, 1 bit per channel). Used for both rect and clear.
- xout  output  8  pixel x to vga_adapter.
- yout  output  7  pixel y to vga_adapter.
- colourout  output  3  pixel colour to vga_adapter.
- plot  output  1  write enable to vga_adapter.
- busy  output  1  high while a request is in progress.
- done  output  1  one-cycle pulse when a request completes.

Behaviour:
- Reset: all outputs driven to 0; state IDLE; internal counters 0. Reset wins over start on the same edge.
- Reset mid-draw: the next edge returns to IDLE with plot=0 and busy=0. No done pulse is produced and remaining pixels are abandoned.
- States:
  - IDLE: busy=0.
  - DRAW: busy=1.
  - DONE: single cycle, done=1, busy=0.
  - DONE goes to IDLE unconditionally. A start seen in DONE is accepted exactly as it would be in IDLE.
- Accept:
  - A start with busy=0 is accepted on that edge.
  - On accept, the block latches x0, y0, width, height and colour_in.
  - If clear=1, the latched values are replaced with x0=0, y0=0, width=SCREEN_W, height=SCREEN_H.
  - A start with busy=1 is ignored entirely, including any input changes.
- Zero size: if width=0 or height=0, the accept edge goes directly to DONE. No plot cycle occurs.
- Otherwise, the accept edge enters DRAW and registers the first pixel (x0, y0) onto the outputs in the same edge. The first pixel is therefore visible in the cycle after start.
- Scan order: row-major, x inner.
  - Pixel k is at xoff = k mod width, yoff = k div width.
  - Exactly width*height DRAW cycles occur; one pixel per cycle with no gaps.
- Address arithmetic:
  - Pixel x = x0+xoff, computed 9 bits wide. Pixel y = y0+yoff, computed 8 bits wide.
  - xout and yout carry the low 8 and 7 bits respectively.
- Clipping:
  - If the 9-bit x >= SCREEN_W or the 8-bit y >= SCREEN_H, plot=0 for that cycle.
  - Clipped cycles are still consumed, so total latency stays deterministic.
  - Out-of-range coordinates are never written.
- colourout holds the latched colour for the whole request. It is 0 in IDLE.
- plot is 0 in IDLE and DONE.
- Completion: the edge after the last pixel cycle enters DONE with plot=0, done=1 and busy=0.
- Total latency: accept edge + width*height cycles, then the done cycle. busy is high for exactly width*height cycles.
- Coordinate values in non-plot cycles are don't-care, except immediately after reset, where they must be 0.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 -> xout, yout, colourout, plot, busy and done are all 0; no request is accepted.
- Rect: start with x0=10, y0=20, width=3, height=2, colour_in=3'b100 in cycle 0 ->
  - plot=1 in cycles 1-6 at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), with colourout=100;
  - busy=1 in cycles 1-6;
  - done=1 only in cycle 7.
- Clip: x0=158, y0=119, width=4, height=2, colour_in=3'b101 ->
  - 8 DRAW cycles;
  - plot=1 only for (158,119) and (159,119);
  - done in cycle 9.
- Zero size and clear:
  - width=0, height=5 -> done=1 in cycle 1, plot never asserts.
  - clear=1, colour_in=000 -> 19200 consecutive plot cycles, the last at (159,119), then done in cycle 19201.
- Busy/reset:
  - A second start in cycle 3 of the 3x2 rect is ignored; the output sequence is unchanged.
  - A new start in the done cycle is accepted; its first pixel appears the next cycle.
  - reset_n=0 in cycle 4 -> plot=0 and busy=0 from cycle 5 onward, with no done pulse.

Source files
------------

// File: rtl/rect_plotter.sv
// rect_plotter: streams one pixel per clock to vga_adapter for a
// rectangle fill or a full-screen clear, clipping off-screen pixels.
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] width,
  input  logic [6:0] height,
  input  logic [2:0] colour_in,
  output logic [7:0] xout,
  output logic [6:0] yout,
  output logic [2:0] colourout,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] FULL_W = 8'(SCREEN_W);
  localparam logic [6:0] FULL_H = 7'(SCREEN_H);
  localparam logic [8:0] XLIM = 9'(SCREEN_W);
  localparam logic [7:0] YLIM = 8'(SCREEN_H);

  logic [1:0] state;
  logic [7:0] bx;
  logic [6:0] by;
  logic [7:0] bw;
  logic [6:0] bh;
  logic [7:0] xoff;
  logic [6:0] yoff;

  logic [7:0] rx;
  logic [6:0] ry;
  logic [7:0] rw;
  logic [6:0] rh;
  logic       accept;
  logic       last_col;
  logic       last_row;
  logic [7:0] nxoff;
  logic [6:0] nyoff;
  logic [8:0] px;
  logic [7:0] py;
  logic       in_range;

  // px/py is the pixel registered on this edge: the first pixel
  // of a new request, or the successor of the current one.
  always_comb begin
    rx       = clear ? 8'd0 : x0;
    ry       = clear ? 7'd0 : y0;
    rw       = clear ? FULL_W : width;
    rh       = clear ? FULL_H : height;
    accept   = start && (state != DRAW);
    last_col = (xoff == bw - 8'd1);
    last_row = (yoff == bh - 7'd1);
    nxoff    = last_col ? 8'd0 : xoff + 8'd1;
    nyoff    = last_col ? yoff + 7'd1 : yoff;
    if (accept) begin
      px = {1'b0, rx};
      py = {1'b0, ry};
    end else begin
      px = {1'b0, bx} + {1'b0, nxoff};
      py = {1'b0, by} + {1'b0, nyoff};
    end
    in_range = (px < XLIM) && (py < YLIM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      bx        <= '0;
      by        <= '0;
      bw        <= '0;
      bh        <= '0;
      xoff      <= '0;
      yoff      <= '0;
      xout      <= '0;
      yout      <= '0;
      colourout <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      bx        <= rx;
      by        <= ry;
      bw        <= rw;
      bh        <= rh;
      xoff      <= '0;
      yoff      <= '0;
      colourout <= colour_in;
      if (rw == 8'd0 || rh == 7'd0) begin
        state <= DONE;
        plot  <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        state <= DRAW;
        xout  <= px[7:0];
        yout  <= py[6:0];
        plot  <= in_range;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end else if (state == DRAW) begin
      if (last_col && last_row) begin
        state <= DONE;
        plot  <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        xoff <= nxoff;
        yoff <= nyoff;
        xout <= px[7:0];
        yout <= py[6:0];
        plot <= in_range;
      end
    end else begin
      state     <= IDLE;
      colourout <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter: directed vector table plus a full-screen clear
// sequence, all expected values hand-computed.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       clear;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] width;
  logic [6:0] height;
  logic [2:0] colour_in;
  logic [7:0] xout;
  logic [6:0] yout;
  logic [2:0] colourout;
  logic       plot;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rect_plotter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .clear     (clear),
    .x0        (x0),
    .y0        (y0),
    .width     (width),
    .height    (height),
    .colour_in (colour_in),
    .xout      (xout),
    .yout      (yout),
    .colourout (colourout),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic       rst_n;
    logic       st;
    logic       clr;
    logic [7:0] vx;
    logic [6:0] vy;
    logic [7:0] vw;
    logic [6:0] vh;
    logic [2:0] vc;
    logic       e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
    logic       e_busy;
    logic       e_done;
    logic       chk_xy;
    logic       chk_col;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic rst_n, logic st, logic clr,
    logic [7:0] vx, logic [6:0] vy,
    logic [7:0] vw, logic [6:0] vh, logic [2:0] vc,
    logic e_plot, logic [7:0] e_x, logic [6:0] e_y,
    logic [2:0] e_col, logic e_busy, logic e_done,
    logic chk_xy, logic chk_col);
    vec_t v;
    v.rst_n = rst_n; v.st = st; v.clr = clr;
    v.vx = vx; v.vy = vy; v.vw = vw; v.vh = vh; v.vc = vc;
    v.e_plot = e_plot; v.e_x = e_x; v.e_y = e_y;
    v.e_col = e_col; v.e_busy = e_busy; v.e_done = e_done;
    v.chk_xy = chk_xy; v.chk_col = chk_col;
    return v;
  endfunction

  function automatic vec_t nop(
    logic e_plot, logic [7:0] e_x, logic [6:0] e_y,
    logic [2:0] e_col, logic e_busy, logic e_done,
    logic chk_xy, logic chk_col);
    return mk(1, 0, 0, 0, 0, 0, 0, 0,
              e_plot, e_x, e_y, e_col, e_busy, e_done,
              chk_xy, chk_col);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; clear = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; colour_in = '0;

    // reset held 3 cycles with start high
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 10, 20, 3, 2, 4,
                       0, 0, 0, 0, 0, 0, 1, 1));
    // 3x2 rect; second start in cycle 3 is ignored
    tbl.push_back(mk(1, 1, 0, 10, 20, 3, 2, 4,
                     1, 10, 20, 4, 1, 0, 1, 1));
    tbl.push_back(nop(1, 11, 20, 4, 1, 0, 1, 1));
    tbl.push_back(nop(1, 12, 20, 4, 1, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 50, 5, 1, 1, 1,
                     1, 10, 21, 4, 1, 0, 1, 1));
    tbl.push_back(nop(1, 11, 21, 4, 1, 0, 1, 1));
    tbl.push_back(nop(1, 12, 21, 4, 1, 0, 1, 1));
    tbl.push_back(nop(0, 0, 0, 0, 0, 1, 0, 0));
    // clip request started in the done cycle
    tbl.push_back(mk(1, 1, 0, 158, 119, 4, 2, 5,
                     1, 158, 119, 5, 1, 0, 1, 1));
    tbl.push_back(nop(1, 159, 119, 5, 1, 0, 1, 1));
    for (int i = 0; i < 6; i++)
      tbl.push_back(nop(0, 0, 0, 5, 1, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0, 0, 1));
    // zero width, then zero height
    tbl.push_back(mk(1, 1, 0, 30, 30, 0, 5, 6,
                     0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 30, 30, 5, 0, 6,
                     0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0, 0, 1));
    // reset in cycle 4 of a 3x2 rect
    tbl.push_back(mk(1, 1, 0, 10, 20, 3, 2, 4,
                     1, 10, 20, 4, 1, 0, 1, 1));
    tbl.push_back(nop(1, 11, 20, 4, 1, 0, 1, 1));
    tbl.push_back(nop(1, 12, 20, 4, 1, 0, 1, 1));
    tbl.push_back(nop(1, 10, 21, 4, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset_n   = tbl[i].rst_n;
      start     = tbl[i].st;
      clear     = tbl[i].clr;
      x0        = tbl[i].vx;
      y0        = tbl[i].vy;
      width     = tbl[i].vw;
      height    = tbl[i].vh;
      colour_in = tbl[i].vc;
      step();
      chk($sformatf("v%0d plot", i), plot, tbl[i].e_plot);
      chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d done", i), done, tbl[i].e_done);
      if (tbl[i].chk_xy) begin
        chk($sformatf("v%0d x", i), xout, tbl[i].e_x);
        chk($sformatf("v%0d y", i), yout, tbl[i].e_y);
      end
      if (tbl[i].chk_col)
        chk($sformatf("v%0d col", i), colourout, tbl[i].e_col);
    end

    // full clear; rect fields must be overridden
    reset_n = 1'b1; start = 1'b1; clear = 1'b1;
    x0 = 8'd7; y0 = 7'd3; width = 8'd2; height = 7'd2;
    colour_in = 3'b000;
    step();
    start = 1'b0; clear = 1'b0;
    for (int k = 0; k < 19200; k++) begin
      chk($sformatf("clr px%0d {plot,busy,done,x,y}", k),
          {plot, busy, done, xout, yout},
          {1'b1, 1'b1, 1'b0, 8'(k % 160), 7'(k / 160)});
      step();
    end
    chk("clr done", done, 1'b1);
    chk("clr done plot", plot, 1'b0);
    chk("clr done busy", busy, 1'b0);
    step();
    chk("clr idle done", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
